// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC moving-average / threshold block.
package adc_pkg;

  localparam int ADC_W = 12;

  localparam logic [ADC_W-1:0] TH_HIGH_DEF = 12'd3000;
  localparam logic [ADC_W-1:0] TH_LOW_DEF  = 12'd2800;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_t;

endpackage

// File: rtl/adc_sample_sync.sv
// Double-registers the quasi-static ADC word and produces a one-cycle accept pulse
// once per sample period, deferred until two consecutive captures agree.
module adc_sample_sync
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV = 100
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] reading,
  input  logic             clear,
  output logic             accept,
  output logic [ADC_W-1:0] sample
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_DIV - 1);

  logic [ADC_W-1:0] r1_reg;
  logic [ADC_W-1:0] r2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pending_reg;
  logic             stable;
  logic             tick;

  assign stable = (r1_reg == r2_reg);
  assign tick   = (cnt_reg == '0);

  // A tick arriving while a sample is still pending merges into the same request.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r1_reg      <= '0;
      r2_reg      <= '0;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      r1_reg <= reading;
      r2_reg <= r1_reg;
      if (clear) begin
        cnt_reg     <= RELOAD;
        pending_reg <= 1'b0;
      end else begin
        cnt_reg     <= tick ? RELOAD : cnt_reg - 1'b1;
        pending_reg <= tick | (pending_reg & ~stable);
      end
    end
  end

  assign accept = pending_reg & stable;
  assign sample = r2_reg;

endmodule

// File: rtl/adc_avg_threshold.sv
// Moving average over a 2^LOG2_DEPTH circular window of ADC samples, with a
// registered average, one-cycle valid strobe and a hysteresis threshold flag.
module adc_avg_threshold
  import adc_pkg::*;
#(
  parameter int               SAMPLE_DIV = 100,
  parameter int               LOG2_DEPTH = 3,
  parameter logic [ADC_W-1:0] TH_HIGH    = TH_HIGH_DEF,
  parameter logic [ADC_W-1:0] TH_LOW     = TH_LOW_DEF
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] reading,
  input  logic             clear,
  output logic [ADC_W-1:0] avg,
  output logic             avg_valid,
  output logic             above,
  output logic             primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = ADC_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] LAST_FILL = (LOG2_DEPTH + 1)'(DEPTH - 1);

  logic                  accept;
  logic [ADC_W-1:0]      sample;
  logic                  take;

  logic [ADC_W-1:0]      win_mem [DEPTH];
  logic [SUM_W-1:0]      sum_reg;
  logic [LOG2_DEPTH-1:0] ptr_reg;
  logic [LOG2_DEPTH:0]   fill_reg;
  logic [LOG2_DEPTH:0]   fill_next;
  avg_state_t            state_reg;
  avg_state_t            state_next;
  logic                  publish_reg;
  logic                  publish_next;
  logic [ADC_W-1:0]      avg_reg;
  logic                  avg_valid_reg;
  logic                  above_reg;

  adc_sample_sync #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sync (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .reading(reading),
    .clear  (clear),
    .accept (accept),
    .sample (sample)
  );

  // clear takes priority: a sample landing on the clear cycle is discarded.
  assign take = accept & ~clear;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
      sum_reg <= '0;
      ptr_reg <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
      sum_reg <= '0;
      ptr_reg <= '0;
    end else if (take) begin
      win_mem[ptr_reg] <= sample;
      sum_reg          <= sum_reg + SUM_W'(sample) - SUM_W'(win_mem[ptr_reg]);
      ptr_reg          <= ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= FILL;
      fill_reg    <= '0;
      publish_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fill_reg    <= fill_next;
      publish_reg <= publish_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    fill_next    = fill_reg;
    publish_next = 1'b0;
    if (clear) begin
      state_next = FILL;
      fill_next  = '0;
    end else if (take) begin
      case (state_reg)
        FILL: begin
          fill_next = fill_reg + 1'b1;
          if (fill_reg == LAST_FILL) begin
            state_next   = RUN;
            publish_next = 1'b1;
          end
        end
        RUN:     publish_next = 1'b1;
        default: state_next = FILL;
      endcase
    end
  end

  // Hysteresis looks at the average already on the output during its valid cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
      above_reg     <= 1'b0;
    end else if (clear) begin
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
      above_reg     <= 1'b0;
    end else begin
      avg_valid_reg <= publish_reg;
      if (publish_reg) avg_reg <= sum_reg[SUM_W-1:LOG2_DEPTH];
      if (avg_valid_reg) begin
        if (avg_reg >= TH_HIGH)     above_reg <= 1'b1;
        else if (avg_reg <= TH_LOW) above_reg <= 1'b0;
      end
    end
  end

  assign avg       = avg_reg;
  assign avg_valid = avg_valid_reg;
  assign above     = above_reg;
  assign primed    = (state_reg == RUN);

endmodule

// File: tb/tb_adc_avg_threshold.sv
// Randomized bench for adc_avg_threshold against a queue-based moving-average model.
module tb_adc_avg_threshold;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic [11:0] reading;
  logic        clear;
  logic [11:0] avg;
  logic        avg_valid;
  logic        above;
  logic        primed;

  adc_avg_threshold dut (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .reading  (reading),
    .clear    (clear),
    .avg      (avg),
    .avg_valid(avg_valid),
    .above    (above),
    .primed   (primed)
  );

  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: tick schedule, last two captured readings, window contents
  int unsigned since;
  bit          pending;
  logic [11:0] m_r1, m_r2;
  int          win[$];
  int          m_acc;
  bit          pub_next;
  int          pub_avg;
  int          e_avg;
  bit          e_valid, e_above, e_primed;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    since = 0; pending = 0; m_r1 = '0; m_r2 = '0; win.delete();
    pub_next = 0; pub_avg = 0; e_avg = 0; e_valid = 0; e_above = 0; e_primed = 0;
  endtask

  // Effect of one rising edge, using the inputs held across it.
  task automatic model_edge();
    bit tick, stable, acc;
    int s;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tick   = (since % 100 == 0);
    since++;
    stable = (m_r1 == m_r2);
    acc    = pending && stable && !clear;
    if (clear) begin
      win.delete(); pending = 0; since = 1;
      e_avg = 0; e_valid = 0; e_above = 0; e_primed = 0; pub_next = 0;
    end else begin
      if (e_valid) begin
        if (e_avg >= 3000) e_above = 1;
        else if (e_avg <= 2800) e_above = 0;
      end
      e_valid = pub_next;
      if (pub_next) e_avg = pub_avg;
      pub_next = 0;
      if (acc) begin
        m_acc++;
        win.push_back(int'(m_r2));
        if (win.size() > 8) void'(win.pop_front());
        if (win.size() == 8) begin
          s = 0;
          foreach (win[i]) s += win[i];
          pub_next = 1; pub_avg = s / 8; e_primed = 1;
        end
      end
      pending = tick ? 1'b1 : (pending && !stable);
    end
    m_r2 = m_r1;
    m_r1 = reading;
  endtask

  function automatic bit would_accept();
    return pending && (m_r1 == m_r2);
  endfunction

  task automatic cycle();
    @(negedge clk_50);
    model_edge();
    chk("avg", int'(avg), e_avg);
    chk("avg_valid", int'(avg_valid), int'(e_valid));
    chk("above", int'(above), int'(e_above));
    chk("primed", int'(primed), int'(e_primed));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 50 == 0) reading = 12'($urandom_range(0, 4095));
      cycle();
    end
  endtask

  task automatic hold(input int v, input int n);
    reading = 12'(v);
    run(n);
  endtask

  initial begin
    int v;
    int budget;
    reset_n = 1'b0; clear = 1'b0; reading = '0;
    model_reset();
    m_acc = 0;
    run(3);
    chk("reset_avg", int'(avg), 0);
    chk("reset_primed", int'(primed), 0);
    reset_n = 1'b1;

    // Constant mid-scale input
    hold(2048, 1000);
    chk("t1_avg", int'(avg), 2048);
    chk("t1_primed", int'(primed), 1);
    chk("t1_above", int'(above), 0);

    // Step from 1000 to 4000
    hold(1000, 900);
    chk("t2_avg_low", int'(avg), 1000);
    hold(4000, 900);
    chk("t2_avg_high", int'(avg), 4000);
    chk("t2_above", int'(above), 1);

    // Hysteresis band
    hold(3100, 900);
    hold(2900, 900);
    chk("t3_avg2900", int'(avg), 2900);
    chk("t3_hold", int'(above), 1);
    hold(2800, 900);
    chk("t3_clear", int'(above), 0);
    hold(3000, 900);
    chk("t3_reset", int'(above), 1);

    // Reading toggling around the tick
    for (int k = 0; k < 10; k++) begin
      budget = 0;
      while ((since % 100) != 97 && budget < 200) begin
        cycle(); budget++;
      end
      if (budget >= 200) chk("t4_align_timeout", budget, 0);
      v = int'(reading);
      for (int j = 0; j < 5; j++) begin
        v = (v + int'($urandom_range(1, 4095))) % 4096;
        reading = 12'(v);
        cycle();
      end
      run(100);
    end

    // clear on the accept cycle after five samples
    clear = 1'b1; cycle(); clear = 1'b0;
    reading = 12'($urandom_range(0, 4095));
    m_acc = 0;
    budget = 0;
    while (!(m_acc >= 5 && would_accept()) && budget < 2000) begin
      cycle(); budget++;
    end
    if (budget >= 2000) chk("t5_timeout", budget, 0);
    clear = 1'b1; cycle(); clear = 1'b0;
    chk("t5_primed", int'(primed), 0);
    chk("t5_avg", int'(avg), 0);
    run_random(900);

    // Full-scale window, then async reset mid-window
    hold(4095, 900);
    chk("t6_avg", int'(avg), 4095);
    run_random(300);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_avg", int'(avg), 0);
    chk("t6_rst_valid", int'(avg_valid), 0);
    chk("t6_rst_above", int'(above), 0);
    chk("t6_rst_primed", int'(primed), 0);
    run(3);
    reset_n = 1'b1;
    run_random(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
